// File: rtl/fifo_sync_param.sv
// Single-clock synchronous FIFO with fill count, almost flags,
// overflow/underflow pulses and optional first-word-fall-through.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   datain, write      write data and request
//   read               read request
//   dataout            read data (registered, or head word when FWFT=1)
//   full, empty        occupancy at DEPTH / zero
//   almost_full        count >= AF_THRESH
//   almost_empty       count <= AE_THRESH
//   count              current occupancy
//   overflow           one-cycle pulse for a refused write
//   underflow          one-cycle pulse for a refused read

module fifo_sync_param #(
  parameter  int DW        = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = 14,
  parameter  int AE_THRESH = 2,
  parameter  int FWFT      = 0,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] datain,
  input  logic          write,
  input  logic          read,
  output logic [DW-1:0] dataout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;

  logic          wr_ok;
  logic          rd_ok;
  logic [CW-1:0] count_nxt;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // A read frees a slot, so a full FIFO can
  // still accept a write in the same cycle.
  always_comb begin
    rd_ok      = read & ~empty;
    wr_ok      = write & (~full | rd_ok);
    wr_ptr_nxt = wr_ok ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = rd_ok ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is never cleared; reset only
  // blocks the write in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Status flags come from the post-edge
  // count so they line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      overflow     <= write & ~wr_ok;
      underflow    <= read & ~rd_ok;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // dataout tracks the head entry. The
      // head changes on the first write into
      // an empty FIFO and on every pop. When
      // the last word is popped alongside a
      // write, the new word is the head and
      // is taken straight from datain.
      always_ff @(posedge clk) begin
        if (rst) begin
          dataout <= '0;
        end else if (empty && wr_ok) begin
          dataout <= datain;
        end else if (rd_ok && count == CW'(1)) begin
          if (wr_ok) begin
            dataout <= datain;
          end
        end else if (rd_ok) begin
          dataout <= mem[rd_ptr_nxt];
        end
      end
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          dataout <= '0;
        end else if (rd_ok) begin
          dataout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard mode at depth 4,
// wrap at depth 5, and first-word-fall-through at depth 4.

module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // u0: DEPTH=4, FWFT=0
  logic [7:0] d0, q0;
  logic w0, r0, f0, e0, af0, ae0, ov0, un0;
  logic [2:0] c0;
  // u1: DEPTH=5, FWFT=0
  logic [7:0] d1, q1;
  logic w1, r1, f1, e1, af1, ae1, ov1, un1;
  logic [2:0] c1;
  // u2: DEPTH=4, FWFT=1
  logic [7:0] d2, q2;
  logic w2, r2, f2, e2, af2, ae2, ov2, un2;
  logic [2:0] c2;

  fifo_sync_param #(
    .DW(8), .DEPTH(4), .AF_THRESH(3),
    .AE_THRESH(1), .FWFT(0)
  ) u0 (
    .clk(clk), .rst(rst), .datain(d0),
    .write(w0), .read(r0), .dataout(q0),
    .full(f0), .empty(e0),
    .almost_full(af0), .almost_empty(ae0),
    .count(c0), .overflow(ov0), .underflow(un0)
  );

  fifo_sync_param #(
    .DW(8), .DEPTH(5), .AF_THRESH(3),
    .AE_THRESH(1), .FWFT(0)
  ) u1 (
    .clk(clk), .rst(rst), .datain(d1),
    .write(w1), .read(r1), .dataout(q1),
    .full(f1), .empty(e1),
    .almost_full(af1), .almost_empty(ae1),
    .count(c1), .overflow(ov1), .underflow(un1)
  );

  fifo_sync_param #(
    .DW(8), .DEPTH(4), .AF_THRESH(3),
    .AE_THRESH(1), .FWFT(1)
  ) u2 (
    .clk(clk), .rst(rst), .datain(d2),
    .write(w2), .read(r2), .dataout(q2),
    .full(f2), .empty(e2),
    .almost_full(af2), .almost_empty(ae2),
    .count(c2), .overflow(ov2), .underflow(un2)
  );

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] exp_d;
  logic [7:0] fill_w[4];
  logic [7:0] wrap_w[12];
  int wi, ri, mc;
  bit dw, dr;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fill_w[0] = 8'hA1; fill_w[1] = 8'hB2;
    fill_w[2] = 8'hC3; fill_w[3] = 8'hD4;
    for (int i = 0; i < 12; i++)
      wrap_w[i] = 8'(8'h10 + i * 7);
    d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF;
    w0 = 1; r0 = 1; w1 = 1; r1 = 1;
    w2 = 1; r2 = 1;

    // 1: reset with write=read held high
    rst = 1;
    tick();
    tick();
    chk("rst_empty", e0, 1);
    chk("rst_count", c0, 0);
    chk("rst_dout", q0, 0);
    chk("rst_ov", ov0, 0);
    chk("rst_un", un0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_full", f0, 0);
    chk("rst_u2_empty", e2, 1);
    rst = 0;
    w0 = 0; r0 = 0; w1 = 0; r1 = 0;
    w2 = 0; r2 = 0;
    tick();
    chk("post_rst_ov", ov0, 0);
    chk("post_rst_un", un0, 0);
    chk("post_rst_count", c0, 0);

    // 2: fill to full, then one refused write
    for (int i = 0; i < 4; i++) begin
      d0 = fill_w[i];
      w0 = 1;
      tick();
      sb0.push_back(fill_w[i]);
      chk("fill_count", c0, i + 1);
      chk("fill_af", af0, (i + 1) >= 3);
      chk("fill_ae", ae0, (i + 1) <= 1);
      chk("fill_full", f0, (i + 1) == 4);
      chk("fill_empty", e0, 0);
      chk("fill_ov", ov0, 0);
    end
    d0 = 8'hE5;
    tick();
    chk("ovf_pulse", ov0, 1);
    chk("ovf_count", c0, 4);
    w0 = 0;
    tick();
    chk("ovf_clear", ov0, 0);
    chk("ovf_count2", c0, 4);

    // 3: drain, then one refused read
    for (int i = 0; i < 4; i++) begin
      r0 = 1;
      tick();
      exp_d = sb0.pop_front();
      chk("drain_data", q0, exp_d);
      chk("drain_count", c0, 3 - i);
      chk("drain_un", un0, 0);
    end
    chk("drain_empty", e0, 1);
    tick();
    chk("unf_pulse", un0, 1);
    chk("unf_hold", q0, 8'hD4);
    chk("unf_count", c0, 0);
    r0 = 0;
    tick();
    chk("unf_clear", un0, 0);
    chk("unf_hold2", q0, 8'hD4);

    // 4: full with simultaneous read/write
    for (int i = 0; i < 4; i++) begin
      d0 = 8'(8'h11 * (i + 1));
      w0 = 1;
      tick();
      sb0.push_back(8'(8'h11 * (i + 1)));
    end
    chk("rw_full_pre", f0, 1);
    d0 = 8'h55;
    w0 = 1;
    r0 = 1;
    tick();
    exp_d = sb0.pop_front();
    sb0.push_back(8'h55);
    chk("rw_data", q0, exp_d);
    chk("rw_count", c0, 4);
    chk("rw_ov", ov0, 0);
    chk("rw_full", f0, 1);
    w0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = sb0.pop_front();
      chk("rw_order", q0, exp_d);
    end
    r0 = 0;
    chk("rw_empty", e0, 1);

    // 5: wrap at non-power-of-2 depth
    wi = 0;
    ri = 0;
    mc = 0;
    for (int k = 0; k < 100 && ri < 12; k++) begin
      dw = (wi < 12) && (mc < 5);
      dr = (mc > 0) && ((k % 3) != 0 || wi == 12);
      w1 = dw;
      r1 = dr;
      d1 = (wi < 12) ? wrap_w[wi] : 8'h00;
      tick();
      if (dr) begin
        exp_d = sb1.pop_front();
        chk("wrap_data", q1, exp_d);
        ri++;
        mc--;
      end
      if (dw) begin
        sb1.push_back(wrap_w[wi]);
        wi++;
        mc++;
      end
      chk("wrap_count", c1, mc);
    end
    w1 = 0;
    r1 = 0;
    chk("wrap_done", ri, 12);
    chk("wrap_empty", e1, 1);

    // 6: first-word-fall-through
    d2 = 8'h3C;
    w2 = 1;
    tick();
    w2 = 0;
    chk("fwft_first", q2, 8'h3C);
    chk("fwft_cnt1", c2, 1);
    tick();
    chk("fwft_hold", q2, 8'h3C);
    d2 = 8'h4D;
    w2 = 1;
    tick();
    w2 = 0;
    chk("fwft_head", q2, 8'h3C);
    chk("fwft_cnt2", c2, 2);
    r2 = 1;
    tick();
    r2 = 0;
    chk("fwft_pop", q2, 8'h4D);
    chk("fwft_cnt3", c2, 1);
    d2 = 8'h5E;
    w2 = 1;
    r2 = 1;
    tick();
    r2 = 0;
    chk("fwft_rw1", q2, 8'h5E);
    chk("fwft_cnt4", c2, 1);
    d2 = 8'h6F;
    tick();
    w2 = 0;
    chk("fwft_cnt5", c2, 2);
    chk("fwft_head2", q2, 8'h5E);
    rst = 1;
    tick();
    rst = 0;
    chk("fwft_rst_empty", e2, 1);
    chk("fwft_rst_count", c2, 0);
    chk("fwft_rst_dout", q2, 0);
    d2 = 8'h77;
    w2 = 1;
    r2 = 1;
    tick();
    w2 = 0;
    r2 = 0;
    chk("fwft_nobypass_un", un2, 1);
    chk("fwft_nobypass_cnt", c2, 1);
    chk("fwft_nobypass_d", q2, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
